// File: rtl/load_bin.sv
// load_bin: fetches one bin from BRAM into the SAT engine before solving.
// Streams the bin's clauses into the engine's clause array (one-hot write
// strobe, one clause per cycle), and assembles the bin's var states (looked
// up through the var bin's local-slot -> global-id table) and lvl states
// into packed vectors. Every BRAM read has a 1-cycle latency.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   start_load               one-cycle load request (ignored unless idle)
//   cur_bin_num_i            bin to load, sampled on start_load
//   base_lvl_i               first lvl-state address, sampled on start_load
//   apply_load_o             BRAM mux select, high while busy
//   done_load                one-cycle completion pulse
//   wr_carray_o, clause_o    one-hot clause slot strobe and its clause word
//   var_state_o              packed var states, slot k at [k*W +: W]
//   lvl_states_o             packed lvl states, same packing
//   ram_addr_*_o/ram_data_*_i  clause, var-bin, var-state, lvl-state BRAMs
module load_bin #(
  parameter int unsigned NUM_CLAUSES_A_BIN     = 8,
  parameter int unsigned NUM_VARS_A_BIN        = 8,
  parameter int unsigned NUM_LVLS_A_BIN        = 8,
  parameter int unsigned WIDTH_CLAUSES         = NUM_VARS_A_BIN * 2,
  parameter int unsigned WIDTH_VAR             = 12,
  parameter int unsigned WIDTH_LVL             = 16,
  parameter int unsigned WIDTH_BIN_ID          = 10,
  parameter int unsigned WIDTH_VAR_STATES      = 30,
  parameter int unsigned WIDTH_LVL_STATES      = 30,
  parameter int unsigned ADDR_WIDTH_CLAUSES    = 9,
  parameter int unsigned ADDR_WIDTH_VAR        = 9,
  parameter int unsigned ADDR_WIDTH_VAR_STATES = 9,
  parameter int unsigned ADDR_WIDTH_LVL_STATES = 9
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         start_load,
  input  logic [WIDTH_BIN_ID-1:0]                      cur_bin_num_i,
  input  logic [WIDTH_LVL-1:0]                         base_lvl_i,
  output logic                                         apply_load_o,
  output logic                                         done_load,
  output logic [NUM_CLAUSES_A_BIN-1:0]                 wr_carray_o,
  output logic [WIDTH_CLAUSES-1:0]                     clause_o,
  output logic [WIDTH_VAR_STATES*NUM_VARS_A_BIN-1:0]   var_state_o,
  output logic [WIDTH_LVL_STATES*NUM_LVLS_A_BIN-1:0]   lvl_states_o,
  output logic [ADDR_WIDTH_CLAUSES-1:0]                ram_addr_c_o,
  input  logic [WIDTH_CLAUSES-1:0]                     ram_data_c_i,
  output logic [ADDR_WIDTH_VAR-1:0]                    ram_addr_v_o,
  input  logic [WIDTH_VAR-1:0]                         ram_data_v_i,
  output logic [ADDR_WIDTH_VAR_STATES-1:0]             ram_addr_vs_o,
  input  logic [WIDTH_VAR_STATES-1:0]                  ram_data_vs_i,
  output logic [ADDR_WIDTH_LVL_STATES-1:0]             ram_addr_ls_o,
  input  logic [WIDTH_LVL_STATES-1:0]                  ram_data_ls_i
);

  localparam int unsigned MAX_CV = (NUM_CLAUSES_A_BIN > NUM_VARS_A_BIN) ?
                                   NUM_CLAUSES_A_BIN : NUM_VARS_A_BIN;
  localparam int unsigned M      = (MAX_CV > NUM_LVLS_A_BIN) ? MAX_CV : NUM_LVLS_A_BIN;
  localparam int unsigned CNT_W  = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, next_state;

  logic [CNT_W-1:0] cnt;
  logic [1:0]       drain_cnt;

  // Latched bases and the base selected for the current issue
  logic [ADDR_WIDTH_CLAUSES-1:0]    bc_q, bc_sel;
  logic [ADDR_WIDTH_VAR-1:0]        bv_q, bv_sel;
  logic [ADDR_WIDTH_LVL_STATES-1:0] bl_q, bl_sel;

  // Slot index whose addresses are presented in the coming cycle
  logic             issue_en;
  logic [CNT_W-1:0] issue_idx;
  logic             issue_c, issue_v, issue_l;
  logic             load_start;

  // Per-stream pipeline valids and slot indices
  logic             ca_v, cb_v;
  logic [CNT_W-1:0] ca_idx, cb_idx;
  logic             va_v, vb_v, vc_v, vd_v;
  logic [CNT_W-1:0] va_idx, vb_idx, vc_idx, vd_idx;
  logic             vc_zero, vd_zero;
  logic             la_v, lb_v;
  logic [CNT_W-1:0] la_idx, lb_idx;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next state, issue control and base selection
  always_comb begin
    next_state = state;
    issue_en   = 1'b0;
    issue_idx  = '0;
    load_start = 1'b0;
    bc_sel     = bc_q;
    bv_sel     = bv_q;
    bl_sel     = bl_q;
    case (state)
      IDLE: begin
        if (start_load) begin
          next_state = LOAD;
          issue_en   = 1'b1;
          load_start = 1'b1;
          bc_sel     = ADDR_WIDTH_CLAUSES'(32'(cur_bin_num_i) * NUM_CLAUSES_A_BIN);
          bv_sel     = ADDR_WIDTH_VAR'(32'(cur_bin_num_i) * NUM_VARS_A_BIN);
          bl_sel     = ADDR_WIDTH_LVL_STATES'(base_lvl_i);
        end
      end
      LOAD: begin
        if (cnt == CNT_W'(M - 1)) begin
          next_state = DRAIN;
        end else begin
          issue_en  = 1'b1;
          issue_idx = cnt + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (drain_cnt == 2'd2) next_state = DONE;
      end
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
    issue_c = issue_en && (32'(issue_idx) < NUM_CLAUSES_A_BIN);
    issue_v = issue_en && (32'(issue_idx) < NUM_VARS_A_BIN);
    issue_l = issue_en && (32'(issue_idx) < NUM_LVLS_A_BIN);
  end

  // Datapath: counters, address issue, read-data pipelines, slot writes
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt           <= '0;
      drain_cnt     <= '0;
      bc_q          <= '0;
      bv_q          <= '0;
      bl_q          <= '0;
      apply_load_o  <= 1'b0;
      done_load     <= 1'b0;
      wr_carray_o   <= '0;
      clause_o      <= '0;
      var_state_o   <= '0;
      lvl_states_o  <= '0;
      ram_addr_c_o  <= '0;
      ram_addr_v_o  <= '0;
      ram_addr_vs_o <= '0;
      ram_addr_ls_o <= '0;
      ca_v <= 1'b0; cb_v <= 1'b0; ca_idx <= '0; cb_idx <= '0;
      va_v <= 1'b0; vb_v <= 1'b0; vc_v <= 1'b0; vd_v <= 1'b0;
      va_idx <= '0; vb_idx <= '0; vc_idx <= '0; vd_idx <= '0;
      vc_zero <= 1'b0; vd_zero <= 1'b0;
      la_v <= 1'b0; lb_v <= 1'b0; la_idx <= '0; lb_idx <= '0;
    end else begin
      apply_load_o <= (next_state != IDLE);
      done_load    <= (next_state == DONE);

      if (issue_en) cnt <= issue_idx;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;

      if (load_start) begin
        bc_q <= bc_sel;
        bv_q <= bv_sel;
        bl_q <= bl_sel;
      end

      // Address issue; each stream parks at 0 once its count is used up
      ram_addr_c_o  <= issue_c ? ADDR_WIDTH_CLAUSES'(bc_sel + ADDR_WIDTH_CLAUSES'(issue_idx)) : '0;
      ram_addr_v_o  <= issue_v ? ADDR_WIDTH_VAR'(bv_sel + ADDR_WIDTH_VAR'(issue_idx)) : '0;
      ram_addr_ls_o <= issue_l ? ADDR_WIDTH_LVL_STATES'(bl_sel + ADDR_WIDTH_LVL_STATES'(issue_idx)) : '0;

      // Clause stream: address stage, data stage, then strobe
      ca_v   <= issue_c;
      ca_idx <= issue_idx;
      cb_v   <= ca_v;
      cb_idx <= ca_idx;
      wr_carray_o <= cb_v ? (NUM_CLAUSES_A_BIN'(1) << cb_idx) : '0;
      clause_o    <= cb_v ? ram_data_c_i : '0;

      // Var stream: the global id read back becomes the var-state address
      va_v    <= issue_v;
      va_idx  <= issue_idx;
      vb_v    <= va_v;
      vb_idx  <= va_idx;
      ram_addr_vs_o <= vb_v ? ADDR_WIDTH_VAR_STATES'(ram_data_v_i) : '0;
      vc_v    <= vb_v;
      vc_idx  <= vb_idx;
      vc_zero <= (ram_data_v_i == '0);
      vd_v    <= vc_v;
      vd_idx  <= vc_idx;
      vd_zero <= vc_zero;

      // Lvl stream
      la_v   <= issue_l;
      la_idx <= issue_idx;
      lb_v   <= la_v;
      lb_idx <= la_idx;

      // Slots are wiped on a new load; otherwise filled as data returns
      if (load_start) begin
        var_state_o  <= '0;
        lvl_states_o <= '0;
      end else begin
        if (vd_v)
          var_state_o[32'(vd_idx) * WIDTH_VAR_STATES +: WIDTH_VAR_STATES] <=
            vd_zero ? '0 : ram_data_vs_i;
        if (lb_v)
          lvl_states_o[32'(lb_idx) * WIDTH_LVL_STATES +: WIDTH_LVL_STATES] <= ram_data_ls_i;
      end
    end
  end

endmodule

// File: tb/tb_load_bin.sv
// tb_load_bin: directed, table-driven bench for load_bin with behavioural
// 1-cycle-latency BRAM models for the clause, var-bin, var-state and
// lvl-state memories.
module tb_load_bin;

  localparam int unsigned NC  = 8;
  localparam int unsigned NV  = 8;
  localparam int unsigned NL  = 8;
  localparam int unsigned WC  = 16;
  localparam int unsigned WV  = 12;
  localparam int unsigned WVS = 30;
  localparam int unsigned WLS = 30;

  logic                clk;
  logic                rst;
  logic                start_load;
  logic [9:0]          cur_bin_num_i;
  logic [15:0]         base_lvl_i;
  logic                apply_load_o;
  logic                done_load;
  logic [NC-1:0]       wr_carray_o;
  logic [WC-1:0]       clause_o;
  logic [WVS*NV-1:0]   var_state_o;
  logic [WLS*NL-1:0]   lvl_states_o;
  logic [8:0]          ram_addr_c_o;
  logic [WC-1:0]       ram_data_c_i;
  logic [8:0]          ram_addr_v_o;
  logic [WV-1:0]       ram_data_v_i;
  logic [8:0]          ram_addr_vs_o;
  logic [WVS-1:0]      ram_data_vs_i;
  logic [8:0]          ram_addr_ls_o;
  logic [WLS-1:0]      ram_data_ls_i;

  load_bin dut (
    .clk           (clk),
    .rst           (rst),
    .start_load    (start_load),
    .cur_bin_num_i (cur_bin_num_i),
    .base_lvl_i    (base_lvl_i),
    .apply_load_o  (apply_load_o),
    .done_load     (done_load),
    .wr_carray_o   (wr_carray_o),
    .clause_o      (clause_o),
    .var_state_o   (var_state_o),
    .lvl_states_o  (lvl_states_o),
    .ram_addr_c_o  (ram_addr_c_o),
    .ram_data_c_i  (ram_data_c_i),
    .ram_addr_v_o  (ram_addr_v_o),
    .ram_data_v_i  (ram_data_v_i),
    .ram_addr_vs_o (ram_addr_vs_o),
    .ram_data_vs_i (ram_data_vs_i),
    .ram_addr_ls_o (ram_addr_ls_o),
    .ram_data_ls_i (ram_data_ls_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM models
  logic [WC-1:0]  mem_c  [512];
  logic [WV-1:0]  mem_v  [512];
  logic [WVS-1:0] mem_vs [512];
  logic [WLS-1:0] mem_ls [512];

  always @(posedge clk) begin
    ram_data_c_i  <= mem_c[ram_addr_c_o];
    ram_data_v_i  <= mem_v[ram_addr_v_o];
    ram_data_vs_i <= mem_vs[ram_addr_vs_o];
    ram_data_ls_i <= mem_ls[ram_addr_ls_o];
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] vslot(input int k);
    return 32'(var_state_o[k*WVS +: WVS]);
  endfunction

  function automatic logic [31:0] lslot(input int k);
    return 32'(lvl_states_o[k*WLS +: WLS]);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, " addr_c"},  32'(ram_addr_c_o), 0);
    chk({tag, " addr_v"},  32'(ram_addr_v_o), 0);
    chk({tag, " addr_vs"}, 32'(ram_addr_vs_o), 0);
    chk({tag, " addr_ls"}, 32'(ram_addr_ls_o), 0);
    chk({tag, " wr"},      32'(wr_carray_o), 0);
    chk({tag, " clause"},  32'(clause_o), 0);
    chk({tag, " apply"},   32'(apply_load_o), 0);
    chk({tag, " done"},    32'(done_load), 0);
    chk({tag, " var_state_nonzero"}, 32'(var_state_o != '0), 0);
    chk({tag, " lvl_states_nonzero"}, 32'(lvl_states_o != '0), 0);
  endtask

  // Expected bin-3 slot contents: var-state RAM[id]=id*16, id 0 -> empty
  int exp_var [8] = '{80, 144, 0, 112, 16, 32, 48, 64};

  task automatic chk_bin3_slots(input string tag);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s var slot%0d", tag, k), vslot(k), 32'(exp_var[k]));
      chk($sformatf("%s lvl slot%0d", tag, k), lslot(k), 32'(110 + k));
    end
  endtask

  task automatic pulse_start(input logic [9:0] bin, input logic [15:0] lvl);
    cur_bin_num_i = bin;
    base_lvl_i    = lvl;
    start_load    = 1'b1;
    tick();
    start_load    = 1'b0;
  endtask

  // Waits (bounded) for done_load; returns number of pulses seen
  task automatic wait_done(input string tag, input int budget);
    int seen;
    seen = 0;
    for (int i = 0; i < budget && seen == 0; i++) begin
      if (done_load) seen++;
      else tick();
    end
    chk({tag, " done seen"}, 32'(seen), 1);
  endtask

  typedef struct {
    int addr_c;
    int addr_v;
    int addr_ls;
    int addr_vs;
    int wr;
    int clause;
    int apply;
    int done;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int dones, applies;

    // Cycle j = state after the j-th edge following the start_load edge
    tbl[0]  = '{24, 24, 10, 0, 'h00,  0, 1, 0};
    tbl[1]  = '{25, 25, 11, 0, 'h00,  0, 1, 0};
    tbl[2]  = '{26, 26, 12, 5, 'h01, 24, 1, 0};
    tbl[3]  = '{27, 27, 13, 9, 'h02, 25, 1, 0};
    tbl[4]  = '{28, 28, 14, 0, 'h04, 26, 1, 0};
    tbl[5]  = '{29, 29, 15, 7, 'h08, 27, 1, 0};
    tbl[6]  = '{30, 30, 16, 1, 'h10, 28, 1, 0};
    tbl[7]  = '{31, 31, 17, 2, 'h20, 29, 1, 0};
    tbl[8]  = '{ 0,  0,  0, 3, 'h40, 30, 1, 0};
    tbl[9]  = '{ 0,  0,  0, 4, 'h80, 31, 1, 0};
    tbl[10] = '{ 0,  0,  0, 0, 'h00,  0, 1, 0};
    tbl[11] = '{ 0,  0,  0, 0, 'h00,  0, 1, 1};
    tbl[12] = '{ 0,  0,  0, 0, 'h00,  0, 0, 0};

    for (int a = 0; a < 512; a++) begin
      mem_c[a]  = WC'(a);
      mem_v[a]  = '0;
      mem_vs[a] = WVS'(a * 16);
      mem_ls[a] = WLS'(a + 100);
    end
    mem_v[24] = 5; mem_v[25] = 9; mem_v[26] = 0; mem_v[27] = 7;
    mem_v[28] = 1; mem_v[29] = 2; mem_v[30] = 3; mem_v[31] = 4;

    rst           = 1'b0;
    start_load    = 1'b0;
    cur_bin_num_i = '0;
    base_lvl_i    = '0;
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b1;
    tick();

    // Main load: bin 3, lvl base 10, cycle-by-cycle table
    pulse_start(10'd3, 16'd10);
    for (int j = 0; j < 13; j++) begin
      chk($sformatf("j%0d addr_c", j),  32'(ram_addr_c_o),  32'(tbl[j].addr_c));
      chk($sformatf("j%0d addr_v", j),  32'(ram_addr_v_o),  32'(tbl[j].addr_v));
      chk($sformatf("j%0d addr_ls", j), 32'(ram_addr_ls_o), 32'(tbl[j].addr_ls));
      chk($sformatf("j%0d addr_vs", j), 32'(ram_addr_vs_o), 32'(tbl[j].addr_vs));
      chk($sformatf("j%0d wr", j),      32'(wr_carray_o),   32'(tbl[j].wr));
      chk($sformatf("j%0d clause", j),  32'(clause_o),      32'(tbl[j].clause));
      chk($sformatf("j%0d apply", j),   32'(apply_load_o),  32'(tbl[j].apply));
      chk($sformatf("j%0d done", j),    32'(done_load),     32'(tbl[j].done));
      if (j == 11) chk_bin3_slots("main");
      if (j < 12) tick();
    end
    chk_bin3_slots("hold");

    // Second load with a stray start_load mid-LOAD; slots cleared on start
    pulse_start(10'd3, 16'd10);
    dones   = 0;
    applies = 0;
    for (int j = 0; j < 20; j++) begin
      if (j == 0) begin
        chk("clear var slot0", vslot(0), 0);
        chk("clear lvl slot7", lslot(7), 0);
      end
      if (j == 4) begin
        chk("stray start addr_c", 32'(ram_addr_c_o), 28);
        start_load = 1'b0;
      end
      if (done_load) dones++;
      if (apply_load_o) applies++;
      if (j == 3) begin
        cur_bin_num_i = 10'd5;
        start_load    = 1'b1;
      end
      tick();
    end
    chk("stray start done count", 32'(dones), 1);
    chk("stray start apply cycles", 32'(applies), 12);
    chk_bin3_slots("stray");

    // Reset at LOAD cnt=4 aborts the load without done_load
    pulse_start(10'd3, 16'd10);
    for (int j = 0; j < 4; j++) tick();
    rst = 1'b0;
    tick();
    chk_all_zero("abort");
    rst = 1'b1;
    dones = 0;
    for (int j = 0; j < 16; j++) begin
      if (done_load) dones++;
      tick();
    end
    chk("abort no done", 32'(dones), 0);
    pulse_start(10'd3, 16'd10);
    wait_done("after abort", 30);
    chk_bin3_slots("after abort");
    tick();

    // Address wrap: 70*8 = 560 -> 48; lvl base 510 wraps 511 -> 0
    pulse_start(10'd70, 16'd510);
    chk("wrap addr_c j0", 32'(ram_addr_c_o), 48);
    chk("wrap addr_v j0", 32'(ram_addr_v_o), 48);
    chk("wrap addr_ls j0", 32'(ram_addr_ls_o), 510);
    tick();
    chk("wrap addr_ls j1", 32'(ram_addr_ls_o), 511);
    tick();
    chk("wrap addr_ls j2", 32'(ram_addr_ls_o), 0);
    chk("wrap addr_c j2", 32'(ram_addr_c_o), 50);
    chk("wrap wr j2", 32'(wr_carray_o), 'h01);
    chk("wrap clause j2", 32'(clause_o), 48);
    wait_done("wrap", 30);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("wrap lvl slot%0d", k), lslot(k), 32'(((510 + k) % 512) + 100));
      chk($sformatf("wrap var slot%0d", k), vslot(k), 0);
    end
    tick();
    chk("wrap idle apply", 32'(apply_load_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
